// File: rtl/fifo_pkg.sv
// Shared helpers for the router FIFO family: occupancy width and parameter legality.
package fifo_pkg;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int fwft,
                                        input int af_thresh, input int ae_thresh);
    return (depth >= 2) && (ae_thresh < af_thresh) && (af_thresh <= depth) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read address.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with arbitrary depth, fill count, programmable flags,
// synchronous flush, registered overflow/underflow pulses and optional FWFT reads.
module sync_fifo_cfg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         soft_reset,
  input  logic                         write_inc,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         read_inc,
  output logic [DATA_WIDTH-1:0]        data_output,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = fifo_cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  if (!fifo_params_ok(DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_cfg: illegal DEPTH/FWFT/AF_THRESH/AE_THRESH combination");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // Request semantics: write_inc/read_inc are sampled every rising edge and are
  // accepted only against the flags from the start of the cycle (write needs
  // !full, read needs !empty); a rejected request is dropped, never retried,
  // and reported by a one-cycle overflow/underflow pulse after the edge.
  // soft_reset overrides both requests and suppresses the pulses.
  always_comb begin
    wr_en       = write_inc & ~full  & ~soft_reset;
    rd_en       = read_inc  & ~empty & ~soft_reset;
    overflow_d  = write_inc &  full  & ~soft_reset;
    underflow_d = read_inc  &  empty & ~soft_reset;

    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    rd_ptr_d = rd_ptr_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);

    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Standard mode registers the popped word; FWFT exposes the head word directly.
  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (soft_reset) dout_d = '0;
      else if (rd_en) dout_d = rd_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dout_q <= '0;
      else          dout_q <= dout_d;
    end

    assign data_output = dout_q;
  end else begin : g_fwft
    assign data_output = rd_data;
  end

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
